sap1_ula: RTL and testbench
===========================

Name: sap1_ula

Overview:
- 8-bit arithmetic/logic unit for the SAP-1 datapath; operands come from the accumulator (A) and B register.
- One-hot-style operation strobes select add, subtract, AND, OR, XOR or NOT A.
- The result and flags are registered, giving one clock of latency.
- The result reaches the bus port only while the enable Eu is high.

Parameters:
- WIDTH, 8, operand/result width in bits; all values below assume 8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- A  input  WIDTH  operand A (accumulator)
- B  input  WIDTH  operand B (B register)
- Eu  input  1  output enable; gates Out
- Add  input  1  select A+B
- Sub  input  1  select A-B
- AndOp  input  1  select A&B
- OrOp  input  1  select A|B
- XorOp  input  1  select A^B
- NotOp  input  1  select ~A (B ignored)
- Out  output  WIDTH  registered result, forced 0 when not enabled
- Cout  output  1  registered carry (add) / borrow (sub)
- Zero  output  1  registered: result == 0

Behaviour:
- Reset (rst=1 at a rising edge):
  - the result register, Out, Cout and Zero all clear to 0.
  - rst has priority over every other input.
- Each rising edge with rst=0:
  - compute the result from the current A, B and op strobes.
  - load the result register; the new value is visible after that edge (latency 1 cycle).
- Op priority when several strobes are high: Add > Sub > AndOp > OrOp > XorOp > NotOp. Lower-priority strobes are ignored.
- No strobe high: result = 0, Cout = 0, Zero = 1.
- Add:
  - the 9-bit sum A+B gives result = sum[7:0] and Cout = sum[8].
  - wraps modulo 256.
- Sub:
  - result = (A - B) mod 256, computed as A + ~B + 1.
  - Cout = 1 iff A < B (borrow).
- AND/OR/XOR/NOT: bitwise; Cout = 0.
- Zero = 1 iff the 8-bit result is 0, evaluated before Eu gating.
- Eu gating:
  - Out = registered result when the registered Eu is 1, else 0x00.
  - Eu is sampled at the same edge as the operands, so gating also has 1-cycle latency.
  - Cout and Zero are not gated by Eu.
- Operands or strobes changing between edges have no effect until the next edge. There is no combinational path from inputs to outputs.
- Reset asserted mid-sequence clears the outputs at that edge. The first valid result appears one edge after rst deasserts.

Test Plan:
- Reset: assert rst for 2 cycles with Add=1, Eu=1 -> Out=0x00, Cout=0, Zero=0. Release rst -> Out=0xFF after the next edge.
- Enable gating: A=0x0F, B=0xF0, Add=1, Eu=0 -> Out=0x00 but Zero=0. Raise Eu -> Out=0xFF one edge later.
- Arithmetic, A=0x0F, B=0xF0, Eu=1, one strobe at a time:
  - Add -> Out=0xFF, Cout=0.
  - Sub -> Out=0x1F, Cout=1.
  - Add with A=0x80, B=0x80 -> Out=0x00, Cout=1, Zero=1.
  - Sub with A=0x05, B=0x05 -> Out=0x00, Cout=0, Zero=1.
- Logic, A=0x0F, B=0xF0, Eu=1:
  - AndOp -> Out=0x00, Zero=1.
  - OrOp -> Out=0xFF.
  - XorOp -> Out=0xFF.
  - NotOp -> Out=0xF0, Cout=0.
- Priority/idle, A=0x0F, B=0xF0, Eu=1:
  - Add=1 and Sub=1 together -> Out=0xFF (add wins).
  - AndOp+NotOp -> Out=0x00.
  - All strobes low -> Out=0x00, Zero=1.
- Latency: change A from 0x0F to 0x01 with Add=1, B=0xF0 -> Out stays 0xFF until the next rising edge, then becomes 0xF1.

Source files
------------

// File: rtl/sap1_ula_if.sv
// Operand, strobe and result bundle shared between the SAP-1 control/datapath and the ALU.
interface sap1_ula_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Eu;
  logic             Add;
  logic             Sub;
  logic             AndOp;
  logic             OrOp;
  logic             XorOp;
  logic             NotOp;
  logic [WIDTH-1:0] Out;
  logic             Cout;
  logic             Zero;

  modport master (
    output A, B, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp,
    input  Out, Cout, Zero
  );

  modport slave (
    input  A, B, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp,
    output Out, Cout, Zero
  );
endinterface

// File: rtl/sap1_ula.sv
// SAP-1 arithmetic/logic unit: priority-selected operation on A and B, registered result and flags.
// Out is driven only when the registered enable is set; Cout and Zero are always visible.
module sap1_ula #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  sap1_ula_if.slave bus
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_eu;

  // Subtraction as A + ~B + 1: the carry out is high when no borrow occurred.
  always_comb begin
    w_sum  = {1'b0, bus.A} + {1'b0, bus.B};
    w_diff = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};

    w_result = '0;
    w_carry  = 1'b0;
    if (bus.Add) begin
      w_result = w_sum[WIDTH-1:0];
      w_carry  = w_sum[WIDTH];
    end else if (bus.Sub) begin
      w_result = w_diff[WIDTH-1:0];
      w_carry  = ~w_diff[WIDTH];
    end else if (bus.AndOp) begin
      w_result = bus.A & bus.B;
    end else if (bus.OrOp) begin
      w_result = bus.A | bus.B;
    end else if (bus.XorOp) begin
      w_result = bus.A ^ bus.B;
    end else if (bus.NotOp) begin
      w_result = ~bus.A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_eu     <= 1'b0;
    end else begin
      r_result <= w_result;
      r_carry  <= w_carry;
      r_zero   <= (w_result == '0);
      r_eu     <= bus.Eu;
    end
  end

  assign bus.Out  = r_eu ? r_result : '0;
  assign bus.Cout = r_carry;
  assign bus.Zero = r_zero;

endmodule

// File: tb/tb_sap1_ula.sv
// Self-checking bench for sap1_ula: directed literal cases plus randomized traffic against an
// arithmetic reference model checked on every falling edge.
module tb_sap1_ula;

  logic clk = 1'b0;
  logic rst;

  sap1_ula_if #(.WIDTH(8)) bus ();

  sap1_ula #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: what the ALU must be holding after each rising edge.
  int modelResult = 0;
  int modelCarry  = 0;
  int modelZero   = 0;
  int modelEu     = 0;

  always @(posedge clk) begin
    int a;
    int b;
    int r;
    int c;
    a = int'(bus.A);
    b = int'(bus.B);
    r = 0;
    c = 0;
    if (rst) begin
      modelResult = 0;
      modelCarry  = 0;
      modelZero   = 0;
      modelEu     = 0;
    end else begin
      if (bus.Add) begin
        r = (a + b) % 256;
        c = (a + b > 255) ? 1 : 0;
      end else if (bus.Sub) begin
        r = (a - b + 256) % 256;
        c = (a < b) ? 1 : 0;
      end else if (bus.AndOp) begin
        r = a & b;
      end else if (bus.OrOp) begin
        r = a | b;
      end else if (bus.XorOp) begin
        r = a ^ b;
      end else if (bus.NotOp) begin
        r = 255 - a;
      end
      modelResult = r;
      modelCarry  = c;
      modelZero   = (r == 0) ? 1 : 0;
      modelEu     = bus.Eu ? 1 : 0;
    end
  end

  // Continuous comparison against the model, half a cycle away from the active edge.
  always @(negedge clk) begin
    logic [7:0] expOut;
    expOut = (modelEu != 0) ? 8'(modelResult) : 8'h00;
    checks++;
    if (bus.Out !== expOut || bus.Cout !== 1'(modelCarry) || bus.Zero !== 1'(modelZero)) begin
      failures++;
      $display("[TB] FAIL model t=%0t Out=%h want %h Cout=%b want %0d Zero=%b want %0d",
               $time, bus.Out, expOut, bus.Cout, modelCarry, bus.Zero, modelZero);
    end
  end

  task automatic driveInputs(input logic r, input logic [7:0] a, input logic [7:0] b,
                             input logic [5:0] ops, input logic eu);
    rst       = r;
    bus.A     = a;
    bus.B     = b;
    bus.Add   = ops[5];
    bus.Sub   = ops[4];
    bus.AndOp = ops[3];
    bus.OrOp  = ops[2];
    bus.XorOp = ops[1];
    bus.NotOp = ops[0];
    bus.Eu    = eu;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] a, input logic [7:0] b,
                               input logic [5:0] ops, input logic eu);
    driveInputs(r, a, b, ops, eu);
    stepEdge();
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eOut, input logic eCout,
                             input logic eZero);
    checks++;
    if (bus.Out !== eOut || bus.Cout !== eCout || bus.Zero !== eZero) begin
      failures++;
      $display("[TB] FAIL %s Out=%h want %h Cout=%b want %b Zero=%b want %b",
               name, bus.Out, eOut, bus.Cout, eCout, bus.Zero, eZero);
    end
  endtask

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b001000;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_XOR  = 6'b000010;
  localparam logic [5:0] OP_NOT  = 6'b000001;
  localparam logic [5:0] OP_NONE = 6'b000000;

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [5:0] rops;
    logic       rrst;
    logic       reu;

    $display("[TB] starting sap1_ula bench");
    driveInputs(1'b1, 8'h0F, 8'hF0, OP_ADD, 1'b1);

    stepEdge();
    stepEdge();
    checkOutput("reset", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_ADD, 1'b1);
    checkOutput("reset_release", 8'hFF, 1'b0, 1'b0);

    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_ADD, 1'b0);
    checkOutput("eu_low", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_ADD, 1'b1);
    checkOutput("eu_high", 8'hFF, 1'b0, 1'b0);

    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_SUB, 1'b1);
    checkOutput("sub_borrow", 8'h1F, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h80, 8'h80, OP_ADD, 1'b1);
    checkOutput("add_carry_zero", 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h05, 8'h05, OP_SUB, 1'b1);
    checkOutput("sub_equal", 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_AND, 1'b1);
    checkOutput("and", 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_OR, 1'b1);
    checkOutput("or", 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_XOR, 1'b1);
    checkOutput("xor", 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_NOT, 1'b1);
    checkOutput("not", 8'hF0, 1'b0, 1'b0);

    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_ADD | OP_SUB, 1'b1);
    checkOutput("prio_add_sub", 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_AND | OP_NOT, 1'b1);
    checkOutput("prio_and_not", 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_NONE, 1'b1);
    checkOutput("idle", 8'h00, 1'b0, 1'b1);

    applyStimulus(1'b0, 8'h0F, 8'hF0, OP_ADD, 1'b1);
    checkOutput("latency_before", 8'hFF, 1'b0, 1'b0);
    driveInputs(1'b0, 8'h01, 8'hF0, OP_ADD, 1'b1);
    #2;
    checkOutput("latency_hold", 8'hFF, 1'b0, 1'b0);
    stepEdge();
    checkOutput("latency_after", 8'hF1, 1'b0, 1'b0);

    applyStimulus(1'b1, 8'hFF, 8'h01, OP_ADD, 1'b1);
    checkOutput("mid_reset", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'hFF, 8'h01, OP_ADD, 1'b1);
    checkOutput("after_mid_reset", 8'h00, 1'b1, 1'b1);

    // Random traffic biased toward single strobes and corner operand values.
    for (int i = 0; i < 600; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 8'h00;
        1: rb = 8'hFF;
        2: rb = ra;
        default: ;
      endcase
      case ($urandom_range(0, 3))
        0: rops = 6'($urandom);
        1: rops = OP_NONE;
        default: rops = 6'(1 << $urandom_range(0, 5));
      endcase
      rrst = ($urandom_range(0, 31) == 0);
      reu  = ($urandom_range(0, 3) != 0);
      applyStimulus(rrst, ra, rb, rops, reu);
    end

    stepEdge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
